fir_decimator: RTL and testbench

- Decimating FIR filter: the receive-side counterpart of the interpolator FIR path.
- Accepts one input sample per valid/ready handshake and keeps N_COEFFS taps.
- Emits one filtered sample for every DECIM_FACTOR accepted inputs.
- Uses a single time-multiplexed multiply-accumulate unit, one tap per cycle, with a held-output valid/ready handshake downstream.

---
 rtl/fir_decimator.sv | 98 +++++++++
 tb/tb_fir_decimator.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_decimator.sv
// fir_decimator: decimating FIR with one shared MAC (one tap per cycle); FIR_DECIM_PHASE_SYNC_EN adds phase_sync input
module fir_decimator #(
   parameter int INPUT_WORD_SIZE = 16,
   parameter int COEFF_WORD_SIZE = 16,
   parameter int N_COEFFS = 8,
   parameter int DECIM_FACTOR = 2,
   localparam int OUTPUT_WORD_SIZE = INPUT_WORD_SIZE + COEFF_WORD_SIZE + $clog2(N_COEFFS)
) (
   input  logic clk,
   input  logic rst,
   input  logic bypass,
   input  logic [N_COEFFS*COEFF_WORD_SIZE-1:0] coeff,
   input  logic [INPUT_WORD_SIZE-1:0] data_in,
   input  logic valid_in,
   output logic src_ready_out,
   output logic [OUTPUT_WORD_SIZE-1:0] data_out,
   output logic valid_out,
   input  logic dst_ready_in
`ifdef FIR_DECIM_PHASE_SYNC_EN
   ,
   input  logic phase_sync
`endif
);
   localparam int IW = INPUT_WORD_SIZE;
   localparam int CW = COEFF_WORD_SIZE;
   localparam int OW = OUTPUT_WORD_SIZE;
   localparam int KW = $clog2(N_COEFFS);
   localparam int PW = DECIM_FACTOR > 1 ? $clog2(DECIM_FACTOR) : 1;
   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
   state_t state_q, state_d;
   logic signed [IW-1:0] d_q [N_COEFFS];
   logic signed [IW-1:0] d_d [N_COEFFS];
   logic [PW-1:0] phase_q, phase_d;
   logic [KW-1:0] k_q, k_d;
   logic [OW-1:0] acc_q, acc_d, data_out_q, data_out_d, sum;
   logic signed [CW-1:0] c_k;
   logic signed [IW+CW-1:0] prod;
   logic accept, sync, last, fin;
   assign src_ready_out = state_q == IDLE;
   assign valid_out = state_q == OUT;
   assign data_out = data_out_q;
   assign accept = valid_in && src_ready_out;
`ifdef FIR_DECIM_PHASE_SYNC_EN
   assign sync = phase_sync;
`else
   assign sync = 1'b0;
`endif
   // a synced sample is phase 0, so it completes a group only when DECIM_FACTOR is 1
   assign last = sync ? (DECIM_FACTOR == 1) : (phase_q == PW'(DECIM_FACTOR - 1));
   assign fin = k_q == KW'(N_COEFFS - 1);
   assign c_k = coeff[k_q*CW +: CW];
   assign prod = d_q[k_q] * c_k;
   assign sum = acc_q + {{(OW-IW-CW){prod[IW+CW-1]}}, prod};
   always_comb begin
      state_d = state_q;
      d_d = d_q;
      phase_d = phase_q;
      k_d = k_q;
      acc_d = acc_q;
      data_out_d = data_out_q;
      if (state_q == IDLE && accept && bypass) begin
         data_out_d = {{(OW-IW){data_in[IW-1]}}, data_in} << (CW - 1);
         phase_d = '0;
         state_d = OUT;
      end else if (state_q == IDLE && accept) begin
         d_d[0] = data_in;
         for (int i = 1; i < N_COEFFS; i++) d_d[i] = d_q[i-1];
         phase_d = last ? '0 : sync ? PW'(1) : phase_q + 1'b1;
         acc_d = last ? '0 : acc_q;
         k_d = last ? '0 : k_q;
         state_d = last ? MAC : IDLE;
      end else if (state_q == MAC) begin
         acc_d = sum;
         k_d = k_q + 1'b1;
         data_out_d = fin ? sum : data_out_q;
         state_d = fin ? OUT : MAC;
      end else if (state_q == OUT && dst_ready_in) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         for (int i = 0; i < N_COEFFS; i++) d_q[i] <= '0;
         phase_q <= '0;
         k_q <= '0;
         acc_q <= '0;
         data_out_q <= '0;
      end else begin
         state_q <= state_d;
         d_q <= d_d;
         phase_q <= phase_d;
         k_q <= k_d;
         acc_q <= acc_d;
         data_out_q <= data_out_d;
      end
   end
endmodule

// File: tb/tb_fir_decimator.sv
// tb_fir_decimator: table vectors, corner sequences and random traffic against a sample-history reference model
module tb_fir_decimator;
   localparam int N = 8, M = 2, IW = 16, CW = 16, OW = IW + CW + $clog2(N);
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bypass = 1'b0;
   logic valid_in = 1'b0;
   logic dst_ready_in = 1'b1;
   logic [N*CW-1:0] coeff = '0;
   logic [IW-1:0] data_in = '0;
   logic src_ready_out, valid_out;
   logic [OW-1:0] data_out;
`ifdef FIR_DECIM_PHASE_SYNC_EN
   logic phase_sync = 1'b0;
`endif
   fir_decimator #(.INPUT_WORD_SIZE(IW), .COEFF_WORD_SIZE(CW), .N_COEFFS(N), .DECIM_FACTOR(M)) dut (
      .clk(clk), .rst(rst), .bypass(bypass), .coeff(coeff), .data_in(data_in), .valid_in(valid_in),
      .src_ready_out(src_ready_out), .data_out(data_out), .valid_out(valid_out), .dst_ready_in(dst_ready_in)
`ifdef FIR_DECIM_PHASE_SYNC_EN
      , .phase_sync(phase_sync)
`endif
   );
   always #5 clk = ~clk;
   typedef struct {longint val; int lat; int t;} exp_t;
   typedef struct {longint din; bit cset; bit ev; longint ev_val;} vec_t;
   exp_t expq[$];
   vec_t tab[20];
   longint c[N];
   longint hist[$];
   int cnt = 0, checks = 0, failures = 0, cyc = 0;
   bit vprev = 1'b0, rnd_rdy = 1'b0;
   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask
   task automatic push_exp(input longint val, input int lat);
      exp_t e;
      e.val = val;
      e.lat = lat;
      e.t = cyc + 1;
      expq.push_back(e);
   endtask
   task automatic load();
      for (int j = 0; j < N; j++) coeff[j*CW +: CW] = c[j][CW-1:0];
   endtask
   // outputs are compared at handshake time; latency counts the accepting edge as edge 1
   task automatic step();
      if (rnd_rdy) dst_ready_in = 1'($urandom_range(0, 1));
      if (valid_out === 1'b1 && dst_ready_in) begin
         chk("pending_expect", longint'(expq.size() > 0), 1);
         if (expq.size() > 0) begin
            chk("data_out", longint'($signed(data_out)), expq[0].val);
            void'(expq.pop_front());
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (valid_out === 1'b1 && !vprev) begin
         chk("rise_expect", longint'(expq.size() > 0), 1);
         if (expq.size() > 0) chk("latency", longint'(cyc - expq[0].t + 1), longint'(expq[0].lat));
      end
      vprev = valid_out === 1'b1;
   endtask
   task automatic send(input longint din, input bit byp, input bit ps, input bit use_tab, input bit tev, input longint tval);
      int w = 0;
      longint s = 0;
      bit trig;
      while (src_ready_out !== 1'b1 && w < 200) begin
         bypass = 1'($urandom_range(0, 1));
         step();
         w++;
      end
      if (w == 200) chk("accept_wait", longint'(src_ready_out), 1);
      if (byp) begin
         cnt = 0;
         push_exp(din <<< (CW - 1), 1);
      end else begin
         if (ps) cnt = 0;
         hist.push_back(din);
         if (hist.size() > N) void'(hist.pop_front());
         cnt++;
         trig = cnt == M;
         if (trig) cnt = 0;
         for (int i = 0; i < N && i < hist.size(); i++) s += c[i] * hist[hist.size() - 1 - i];
         if (use_tab ? tev : trig) push_exp(use_tab ? tval : s, N + 1);
      end
      bypass = byp;
      data_in = din[IW-1:0];
      valid_in = 1'b1;
`ifdef FIR_DECIM_PHASE_SYNC_EN
      phase_sync = ps;
`endif
      step();
      valid_in = 1'b0;
      bypass = 1'b0;
`ifdef FIR_DECIM_PHASE_SYNC_EN
      phase_sync = 1'b0;
`endif
   endtask
   task automatic drain();
      int w = 0;
      while ((expq.size() > 0 || src_ready_out !== 1'b1) && w < 400) begin
         step();
         w++;
      end
      chk("drain_empty", longint'(expq.size()), 0);
   endtask
   task automatic do_reset();
      rst = 1'b1;
      expq.delete();
      hist.delete();
      cnt = 0;
      step();
      rst = 1'b0;
      vprev = 1'b0;
      chk("rst_valid_out", longint'(valid_out), 0);
      chk("rst_data_out", longint'($signed(data_out)), 0);
      chk("rst_src_ready", longint'(src_ready_out), 1);
   endtask
   task automatic run_table();
      for (int i = 0; i < 20; i++) begin
         if (i == 10) drain();
         for (int j = 0; j < N; j++) c[j] = tab[i].cset ? 1 : j + 1;
         load();
         send(tab[i].din, 1'b0, 1'b0, 1'b1, tab[i].ev, tab[i].ev_val);
      end
      drain();
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end
   initial begin
      longint imp[5] = '{2, 4, 6, 8, 0};
      longint dc[5] = '{200, 400, 600, 800, 800};
      logic [OW-1:0] held;
      int w;
      for (int i = 0; i < 10; i++) begin
         tab[i].din = i == 0 ? 1 : 0;
         tab[i].cset = 1'b0;
         tab[i].ev = i % 2 == 1;
         tab[i].ev_val = imp[i/2];
         tab[i+10].din = 100;
         tab[i+10].cset = 1'b1;
         tab[i+10].ev = i % 2 == 1;
         tab[i+10].ev_val = dc[i/2];
      end
      do_reset();
      run_table();
      // bypass from mid-phase: it must clear the phase so the next pair completes a group
      send(3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send(-2, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      send(5, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send(7, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      drain();
      do_reset();
      for (int j = 0; j < N; j++) c[j] = j + 1;
      load();
      dst_ready_in = 1'b0;
      send(1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send(0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      w = 0;
      while (valid_out !== 1'b1 && w < 40) begin
         step();
         w++;
      end
      held = data_out;
      for (int i = 0; i < 5; i++) begin
         data_in = 16'd777;
         valid_in = 1'b1;
         step();
         chk("bp_valid_out", longint'(valid_out), 1);
         chk("bp_data_hold", longint'($signed(data_out)), longint'($signed(held)));
         chk("bp_src_ready", longint'(src_ready_out), 0);
      end
      valid_in = 1'b0;
      dst_ready_in = 1'b1;
      step();
      chk("rel_valid_out", longint'(valid_out), 0);
      chk("rel_src_ready", longint'(src_ready_out), 1);
      for (int i = 0; i < 4; i++) send(0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      drain();
      send(1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send(0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      step();
      step();
      step();
      do_reset();
      run_table();
`ifdef FIR_DECIM_PHASE_SYNC_EN
      do_reset();
      for (int j = 0; j < N; j++) c[j] = j + 1;
      load();
      send(0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send(1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 9; i++) send(0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      drain();
`endif
      rnd_rdy = 1'b1;
      for (int r = 0; r < 3; r++) begin
         drain();
         for (int j = 0; j < N; j++) c[j] = longint'($signed(16'($urandom)));
         load();
         for (int i = 0; i < 80; i++)
            send(longint'($signed(16'($urandom))), $urandom_range(0, 7) == 0, 1'b0, 1'b0, 1'b0, 0);
      end
      drain();
      rnd_rdy = 1'b0;
      dst_ready_in = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
